// File: rtl/micro_sequencer_if.sv
// rtl/micro_sequencer_if.sv - microcode sequencer bus: control inputs from the datapath, microstate/status back
interface micro_sequencer_if #(
  parameter int STATE_W  = 4,
  parameter int OPCODE_W = 6,
  parameter int COUNT_W  = 16
);
  logic [OPCODE_W-1:0] opcode;
  logic [1:0]          addr_ctl;
  logic                stall;
  logic [STATE_W-1:0]  state;
  logic                instr_done;
  logic [COUNT_W-1:0]  instr_count;
  logic                illegal_op;

  modport master (
    output opcode, addr_ctl, stall,
    input  state, instr_done, instr_count, illegal_op
  );

  modport slave (
    input  opcode, addr_ctl, stall,
    output state, instr_done, instr_count, illegal_op
  );
endinterface

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - microprogram sequencer: fetch/dispatch/sequential next-state, retire counter
// Optional MICRO_SEQ_ILLEGAL_TRAP_EN: illegal dispatch parks at the all-ones state (sticky) until reset.
module micro_sequencer #(
  parameter int STATE_W     = 4,
  parameter int OPCODE_W    = 6,
  parameter int COUNT_W     = 16,
  parameter int FETCH_STATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  micro_sequencer_if.slave bus
);
  localparam logic [STATE_W-1:0]  FETCH   = STATE_W'(FETCH_STATE);
  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);

  logic [STATE_W-1:0] next_state;
  logic               illegal;
  logic               retire;
  logic               frozen;

`ifdef MICRO_SEQ_ILLEGAL_TRAP_EN
  localparam logic [STATE_W-1:0] ILLEGAL_STATE = '1;
  assign frozen = bus.illegal_op;
`else
  localparam logic [STATE_W-1:0] ILLEGAL_STATE = FETCH;
  assign frozen = 1'b0;
`endif

  // Dispatch ignores the current state; the microcode decides where dispatch is legal.
  always_comb begin
    next_state = FETCH;
    illegal    = 1'b0;
    case (bus.addr_ctl)
      2'b00: next_state = FETCH;
      2'b01: begin
        case (bus.opcode)
          OP_R:         next_state = STATE_W'(6);
          OP_LW, OP_SW: next_state = STATE_W'(2);
          OP_BEQ:       next_state = STATE_W'(8);
          OP_J:         next_state = STATE_W'(9);
          OP_ADDI:      next_state = STATE_W'(10);
          default:      illegal    = 1'b1;
        endcase
      end
      2'b10: begin
        case (bus.opcode)
          OP_LW:   next_state = STATE_W'(3);
          OP_SW:   next_state = STATE_W'(5);
          default: illegal    = 1'b1;
        endcase
      end
      default: next_state = bus.state + STATE_W'(1);
    endcase
  end

  assign retire = (bus.addr_ctl == 2'b00) && (bus.state != FETCH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.state       <= FETCH;
      bus.instr_done  <= 1'b0;
      bus.instr_count <= '0;
      bus.illegal_op  <= 1'b0;
    end else begin
      bus.instr_done <= 1'b0;
      // When frozen (trap build only) illegal_op stays set and nothing else moves.
      if (!frozen) begin
        bus.illegal_op <= 1'b0;
        if (!bus.stall) begin
          if (illegal) begin
            bus.state      <= ILLEGAL_STATE;
            bus.illegal_op <= 1'b1;
          end else begin
            bus.state <= next_state;
            if (retire) begin
              bus.instr_done  <= 1'b1;
              bus.instr_count <= bus.instr_count + COUNT_W'(1);
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - table-driven bench for micro_sequencer plus multi-cycle corner sequences
module tb_micro_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  micro_sequencer_if #(.STATE_W(4), .OPCODE_W(6), .COUNT_W(16)) bus ();
  micro_sequencer_if #(.STATE_W(4), .OPCODE_W(6), .COUNT_W(4))  wbus ();

  micro_sequencer #(.STATE_W(4), .OPCODE_W(6), .COUNT_W(16), .FETCH_STATE(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  micro_sequencer #(.STATE_W(4), .OPCODE_W(6), .COUNT_W(4), .FETCH_STATE(0)) u_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (wbus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [1:0]  ac;
    logic        st;
    logic [3:0]  es;
    logic        ed;
    logic [15:0] ec;
  } vec_t;

  vec_t vecs[$];

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] JMP = 6'b000010, ADDI = 6'b001000, RTY = 6'b000000, BAD = 6'b111111;

  task automatic add(input logic [5:0] op, input logic [1:0] ac, input logic st,
                     input logic [3:0] es, input logic ed, input logic [15:0] ec);
    vec_t v;
    v.op = op; v.ac = ac; v.st = st; v.es = es; v.ed = ed; v.ec = ec;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [1:0] ac, input logic st);
    bus.opcode = op; bus.addr_ctl = ac; bus.stall = st;
    tick();
  endtask

  initial begin
    bus.opcode = '0; bus.addr_ctl = 2'b00; bus.stall = 1'b0;
    wbus.opcode = '0; wbus.addr_ctl = 2'b00; wbus.stall = 1'b0;

    // lw: 0 -> 1 -> 2 -> 3 -> 4 -> 0
    add(LW, 2'b11, 0, 4'd1, 0, 16'd0);
    add(LW, 2'b01, 0, 4'd2, 0, 16'd0);
    add(LW, 2'b10, 0, 4'd3, 0, 16'd0);
    add(LW, 2'b11, 0, 4'd4, 0, 16'd0);
    add(LW, 2'b00, 0, 4'd0, 1, 16'd1);
    // beq with 3 stalled cycles in state 8
    add(BEQ, 2'b11, 0, 4'd1, 0, 16'd1);
    add(BEQ, 2'b01, 0, 4'd8, 0, 16'd1);
    add(BEQ, 2'b00, 1, 4'd8, 0, 16'd1);
    add(BEQ, 2'b00, 1, 4'd8, 0, 16'd1);
    add(BEQ, 2'b00, 1, 4'd8, 0, 16'd1);
    add(BEQ, 2'b00, 0, 4'd0, 1, 16'd2);
    // fetch held in state 0 never retires
    for (int i = 0; i < 5; i++) add(BEQ, 2'b00, 0, 4'd0, 0, 16'd2);
    // R-type
    add(RTY, 2'b11, 0, 4'd1, 0, 16'd2);
    add(RTY, 2'b01, 0, 4'd6, 0, 16'd2);
    add(RTY, 2'b11, 0, 4'd7, 0, 16'd2);
    add(RTY, 2'b00, 0, 4'd0, 1, 16'd3);
    // sw through DISP2
    add(SW, 2'b11, 0, 4'd1, 0, 16'd3);
    add(SW, 2'b01, 0, 4'd2, 0, 16'd3);
    add(SW, 2'b10, 0, 4'd5, 0, 16'd3);
    add(SW, 2'b00, 0, 4'd0, 1, 16'd4);
    // addi
    add(ADDI, 2'b11, 0, 4'd1, 0, 16'd4);
    add(ADDI, 2'b01, 0, 4'd10, 0, 16'd4);
    add(ADDI, 2'b11, 0, 4'd11, 0, 16'd4);
    add(ADDI, 2'b00, 0, 4'd0, 1, 16'd5);
    // j dispatched straight from state 0
    add(JMP, 2'b01, 0, 4'd9, 0, 16'd5);
    add(JMP, 2'b00, 0, 4'd0, 1, 16'd6);
    // sequential wrap 15 -> 0 is not a retire
    add(JMP, 2'b01, 0, 4'd9, 0, 16'd6);
    for (int s = 10; s <= 15; s++) add(JMP, 2'b11, 0, 4'(s), 0, 16'd6);
    add(JMP, 2'b11, 0, 4'd0, 0, 16'd6);

    tick(); tick();
    chk("reset_state", 32'(bus.state), 32'd0);
    chk("reset_done", 32'(bus.instr_done), 32'd0);
    chk("reset_count", 32'(bus.instr_count), 32'd0);
    chk("reset_illegal", 32'(bus.illegal_op), 32'd0);
    reset = 1'b1;
    tick();
    chk("idle_state", 32'(bus.state), 32'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].ac, vecs[i].st);
      chk($sformatf("vec%0d_state", i), 32'(bus.state), 32'(vecs[i].es));
      chk($sformatf("vec%0d_done", i), 32'(bus.instr_done), 32'(vecs[i].ed));
      chk($sformatf("vec%0d_count", i), 32'(bus.instr_count), 32'(vecs[i].ec));
      chk($sformatf("vec%0d_illegal", i), 32'(bus.illegal_op), 32'd0);
    end

    // asynchronous reset mid-cycle while in state 7
    drive(RTY, 2'b01, 0);
    drive(RTY, 2'b11, 0);
    chk("pre_areset_state", 32'(bus.state), 32'd7);
    bus.addr_ctl = 2'b00;
    #3 reset = 1'b0;
    #1;
    chk("areset_state", 32'(bus.state), 32'd0);
    chk("areset_count", 32'(bus.instr_count), 32'd0);
    chk("areset_done", 32'(bus.instr_done), 32'd0);
    #2 reset = 1'b1;
    tick();

    // one retire so the illegal case has a nonzero count to preserve
    drive(JMP, 2'b01, 0);
    drive(JMP, 2'b00, 0);
    chk("pre_ill_count", 32'(bus.instr_count), 32'd1);
    drive(BAD, 2'b11, 0);
    drive(BAD, 2'b01, 0);
`ifdef MICRO_SEQ_ILLEGAL_TRAP_EN
    chk("trap_state", 32'(bus.state), 32'hF);
    chk("trap_illegal", 32'(bus.illegal_op), 32'd1);
    for (int i = 0; i < 10; i++) begin
      drive(LW, 2'(i), 1'(i));
      chk($sformatf("trap%0d_state", i), 32'(bus.state), 32'hF);
      chk($sformatf("trap%0d_illegal", i), 32'(bus.illegal_op), 32'd1);
      chk($sformatf("trap%0d_done", i), 32'(bus.instr_done), 32'd0);
      chk($sformatf("trap%0d_count", i), 32'(bus.instr_count), 32'd1);
    end
    bus.addr_ctl = 2'b00;
    reset = 1'b0;
    #1;
    chk("trap_exit_state", 32'(bus.state), 32'd0);
    chk("trap_exit_illegal", 32'(bus.illegal_op), 32'd0);
    tick();
    reset = 1'b1;
    tick();
`else
    chk("ill1_state", 32'(bus.state), 32'd0);
    chk("ill1_pulse", 32'(bus.illegal_op), 32'd1);
    chk("ill1_done", 32'(bus.instr_done), 32'd0);
    chk("ill1_count", 32'(bus.instr_count), 32'd1);
    drive(BEQ, 2'b11, 0);
    chk("ill1_clear", 32'(bus.illegal_op), 32'd0);
    chk("ill1_next_state", 32'(bus.state), 32'd1);
    drive(BEQ, 2'b10, 0);
    chk("ill2_state", 32'(bus.state), 32'd0);
    chk("ill2_pulse", 32'(bus.illegal_op), 32'd1);
    chk("ill2_count", 32'(bus.instr_count), 32'd1);
    drive(BEQ, 2'b00, 0);
    chk("ill2_clear", 32'(bus.illegal_op), 32'd0);
    chk("ill2_no_retire", 32'(bus.instr_done), 32'd0);
`endif

    // counter wrap on the narrow instance: 15 retires reach all-ones, one more wraps
    for (int i = 0; i < 15; i++) begin
      wbus.opcode = JMP; wbus.addr_ctl = 2'b01; tick();
      wbus.addr_ctl = 2'b00; tick();
    end
    chk("wrap_allones", 32'(wbus.instr_count), 32'hF);
    wbus.addr_ctl = 2'b01; tick();
    wbus.addr_ctl = 2'b00; tick();
    chk("wrap_count", 32'(wbus.instr_count), 32'd0);
    chk("wrap_done", 32'(wbus.instr_done), 32'd1);
    tick();
    chk("wrap_done_pulse", 32'(wbus.instr_done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
